// File: rtl/wave_voice_bank.sv
// wave_voice_bank
//   Multi-voice waveform generator and mixer. Each voice steps through a
//   64-step phase grid at a rate set by its period register. It produces a
//   square, saw, triangle or sine sample. The samples are summed into a
//   registered mix.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high; mutes every voice and clears outputs
//   waveform   00 square, 01 saw, 10 triangle, 11 sine (shared by all voices)
//   period     voice i period in clock ticks at [i*PW +: PW]
//   load       load[i] latches voice i period and restarts its phase
//   voice_out  registered per-voice samples, voice i at [i*AW +: AW]
//   mix        registered sum of all voice samples
module wave_voice_bank #(
    parameter int unsigned VOICES = 3,
    parameter int unsigned PW     = 33,
    parameter int unsigned AW     = 4,
    localparam int unsigned MW    = AW + $clog2(VOICES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           waveform,
    input  logic [VOICES*PW-1:0] period,
    input  logic [VOICES-1:0]    load,
    output logic [VOICES*AW-1:0] voice_out,
    output logic [MW-1:0]        mix
);

    localparam int unsigned AMAX = (1 << AW) - 1;

    // Sine table, scaled to the full AW-bit range and rounded to nearest.
    function automatic logic [64*AW-1:0] gen_sine();
        logic [64*AW-1:0] lut;
        real              x;
        int               v;
        lut = '0;
        for (int unsigned k = 0; k < 64; k++) begin
            x = (0.5 + 0.5 * $sin(2.0 * 3.14159265358979323846 * real'(k) / 64.0))
                * real'(AMAX);
            v = $rtoi(x + 0.5);
            lut[k*AW +: AW] = v[AW-1:0];
        end
        return lut;
    endfunction

    localparam logic [64*AW-1:0] SINE_LUT = gen_sine();

    // Sample for phase step s. The non-sine shapes are built as 6-bit values.
    // Only their top AW bits are kept.
    function automatic logic [AW-1:0] shape(input logic [5:0] s, input logic [1:0] wf);
        logic [5:0]  v;
        int unsigned idx;
        case (wf)
            2'b00:   v = s[5] ? 6'd63 : 6'd0;
            2'b01:   v = s;
            2'b10:   v = s[5] ? {~s[4:0], 1'b1} : {s[4:0], 1'b0};
            default: v = '0;
        endcase
        idx = int'(s) * AW;
        if (wf == 2'b11) begin
            return SINE_LUT[idx +: AW];
        end
        return v[5 -: AW];
    endfunction

    logic [PW-1:0] period_r [VOICES];
    logic [PW-1:0] period_n [VOICES];
    logic [PW-1:0] cnt_r    [VOICES];
    logic [PW-1:0] cnt_n    [VOICES];
    logic [PW-1:0] len      [VOICES];
    logic [5:0]    step_r   [VOICES];
    logic [5:0]    step_n   [VOICES];
    logic [AW-1:0] sample_r [VOICES];
    logic [AW-1:0] sample_n [VOICES];
    logic [MW-1:0] mix_n;

    always_comb begin
        mix_n     = '0;
        voice_out = '0;
        for (int unsigned i = 0; i < VOICES; i++) begin
            // Step length: the low 6 period bits are dropped, minimum one clock.
            len[i] = period_r[i] >> 6;
            if (len[i] == '0) begin
                len[i] = PW'(1);
            end

            period_n[i] = period_r[i];
            cnt_n[i]    = cnt_r[i];
            step_n[i]   = step_r[i];
            if (load[i]) begin
                period_n[i] = period[i*PW +: PW];
                cnt_n[i]    = '0;
                step_n[i]   = '0;
            end else if (period_r[i] == '0) begin
                cnt_n[i]  = '0;
                step_n[i] = '0;
            end else if (cnt_r[i] == len[i] - PW'(1)) begin
                cnt_n[i]  = '0;
                step_n[i] = step_r[i] + 6'd1;
            end else begin
                cnt_n[i] = cnt_r[i] + PW'(1);
            end

            // The sample is taken from the post-edge state. A new step and a
            // freshly loaded period are therefore visible on the same edge.
            sample_n[i] = (period_n[i] == '0) ? '0 : shape(step_n[i], waveform);

            voice_out[i*AW +: AW] = sample_r[i];
            mix_n = mix_n + MW'(sample_r[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < VOICES; i++) begin
                period_r[i] <= '0;
                cnt_r[i]    <= '0;
                step_r[i]   <= '0;
                sample_r[i] <= '0;
            end
            mix <= '0;
        end else begin
            for (int unsigned i = 0; i < VOICES; i++) begin
                period_r[i] <= period_n[i];
                cnt_r[i]    <= cnt_n[i];
                step_r[i]   <= step_n[i];
                sample_r[i] <= sample_n[i];
            end
            mix <= mix_n;
        end
    end

endmodule
